// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL generator state encoding and default 100 kHz timing codes.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOW       = 2'd1,
        WAIT_HIGH = 2'd2,
        HIGH      = 2'd3
    } state_t;

    localparam int CPU_CLK = 50_000_000;
    localparam int DIV_CLK = 100_000;

    // Low time is lo+1 clocks, high time hi+2 clocks, so these give a 50 % duty period.
    localparam int DEF_LO_CNT = (CPU_CLK / DIV_CLK) / 2 - 1;
    localparam int DEF_HI_CNT = (CPU_CLK / DIV_CLK) / 2 - 2;

endpackage

// File: rtl/i2c_sync.sv
// Multi-stage flip-flop synchroniser for open-drain pad readback; idles high like the bus.
module i2c_sync
    import i2c_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p <= '1;
        end else begin
            sync_p <= {sync_p[N-2:0], d};
        end
    end

    assign q = sync_p[N-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL timing generator: programmable low/high phases, clock-stretch detection and
// quarter-phase strobes for the bit engine's SDA launch and sample points.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_CNT     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] lo_cnt,
    input  logic [CNT_W-1:0] hi_cnt,
    input  logic             stretch_en,
    input  logic             scl_in,
    output logic             s_clk,
    output logic             scl_oe,
    output logic             strob_down,
    output logic             strob_up,
    output logic             strob_sda,
    output logic             strob_smp,
    output logic             stretching,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_Q    = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] WAIT_THR = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] v);
        return (v < MIN_Q) ? MIN_Q : v;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] lo_q, hi_q;
    logic             s_clk_d, down_d, up_d, latch;
    logic             scl_sync;

    i2c_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (scl_in),
        .q  (scl_sync)
    );

    // Edge strobes are registered with s_clk so they line up with the level change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            lo_q       <= MIN_Q;
            hi_q       <= MIN_Q;
            s_clk      <= 1'b1;
            strob_down <= 1'b0;
            strob_up   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            s_clk      <= s_clk_d;
            strob_down <= down_d;
            strob_up   <= up_d;
            if (latch) begin
                lo_q <= clamp_cnt(lo_cnt);
                hi_q <= clamp_cnt(hi_cnt);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        s_clk_d = s_clk;
        down_d  = 1'b0;
        up_d    = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    latch   = 1'b1;
                    s_clk_d = 1'b0;
                    down_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == lo_q) begin
                    s_clk_d = 1'b1;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    state_d = WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            WAIT_HIGH: begin
                if (!stretch_en || scl_sync) begin
                    up_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = HIGH;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + ONE;
                end
            end
            HIGH: begin
                if (cnt_q == hi_q) begin
                    cnt_d = '0;
                    if (en) begin
                        s_clk_d = 1'b0;
                        down_d  = 1'b1;
                        latch   = 1'b1;
                        state_d = LOW;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The readback lags s_clk by the synchroniser depth, so only a longer low counts as a stretch.
    always_comb begin
        strob_sda  = (state_q == LOW) && (cnt_q == (lo_q >> 1));
        strob_smp  = (state_q == HIGH) && (cnt_q == (hi_q >> 1));
        stretching = (state_q == WAIT_HIGH) && !scl_sync && (wcnt_q >= WAIT_THR);
        busy       = (state_q != IDLE);
        scl_oe     = ~s_clk;
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: phase lengths, strobe positions, stretching, en and reset handling.
module tb_i2c_scl_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] lo_cnt, hi_cnt;
    logic        stretch_en;
    logic        scl_in;
    logic        hold;
    logic        s_clk, scl_oe, strob_down, strob_up, strob_sda, strob_smp, stretching, busy;

    int checks = 0;
    int errors = 0;

    i2c_scl_gen #(
        .CNT_W      (16),
        .SYNC_STAGES(2),
        .MIN_CNT    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .lo_cnt    (lo_cnt),
        .hi_cnt    (hi_cnt),
        .stretch_en(stretch_en),
        .scl_in    (scl_in),
        .s_clk     (s_clk),
        .scl_oe    (scl_oe),
        .strob_down(strob_down),
        .strob_up  (strob_up),
        .strob_sda (strob_sda),
        .strob_smp (strob_smp),
        .stretching(stretching),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Wired-AND pad: a slave holding the line overrides the driven level.
    assign scl_in = s_clk & ~hold;

    int   run = 0, last_low = 0, last_high = 0, since_rise = 0, last_up_rise = 0;
    int   pos_down = 0, pos_up = 0, last_sda = 0, last_smp = 0, last_period = 0, last_hphase = 0;
    int   down_cnt = 0, up_cnt = 0, multi = 0;
    logic prev_s = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            prev_s <= 1'b1;
        end else begin
            if (s_clk != prev_s) begin
                if (s_clk) last_low <= run;
                else       last_high <= run;
                run <= 1;
            end else begin
                run <= run + 1;
            end
            prev_s <= s_clk;
            if (s_clk && !prev_s) since_rise <= 1;
            else                  since_rise <= since_rise + 1;
            if (strob_up) last_up_rise <= since_rise;
            if (strob_down) begin
                last_period <= pos_down;
                last_hphase <= pos_up;
                pos_down    <= 1;
                down_cnt    <= down_cnt + 1;
            end else begin
                pos_down <= pos_down + 1;
            end
            if (strob_sda) last_sda <= pos_down;
            if (strob_up) begin
                pos_up <= 1;
                up_cnt <= up_cnt + 1;
            end else begin
                pos_up <= pos_up + 1;
            end
            if (strob_smp) last_smp <= pos_up;
            if ((int'(strob_down) + int'(strob_up) + int'(strob_sda) + int'(strob_smp)) > 1)
                multi <= multi + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_downs(input string tag, input int n, input int max);
        int start = down_cnt;
        int k = 0;
        while (down_cnt < start + n && k < max) begin
            step();
            k++;
        end
        chk(tag, 32'(down_cnt >= start + n), 32'd1);
    endtask

    task automatic wait_rise(input string tag, input int max);
        int k = 0;
        while (s_clk !== 1'b1 && k < max) begin
            step();
            k++;
        end
        chk(tag, 32'(s_clk), 32'd1);
    endtask

    int u0, dc, k;

    initial begin
        rst = 1'b0; en = 1'b0; lo_cnt = 16'd249; hi_cnt = 16'd248;
        stretch_en = 1'b0; hold = 1'b0;
        step(); step();
        chk("reset_outs", {s_clk, scl_oe, strob_down, strob_up, strob_sda, strob_smp, stretching, busy}, 8'b1000_0000);

        // 100 kHz timing at 50 MHz
        rst = 1'b1; en = 1'b1;
        step();
        chk("first_down", {strob_down, s_clk, scl_oe, busy}, 4'b1011);
        wait_downs("t1_to", 3, 1600);
        chk("t1_low", last_low, 250);
        chk("t1_high", last_high, 250);
        chk("t1_period", last_period, 500);
        chk("t1_sda", last_sda, 124);
        chk("t1_smp", last_smp, 124);
        chk("t1_up_rise", last_up_rise, 1);

        // clamp of tiny codes
        lo_cnt = 16'd0; hi_cnt = 16'd1;
        wait_downs("t2_to", 3, 1000);
        chk("t2_low", last_low, 3);
        chk("t2_high", last_high, 4);
        chk("t2_period", last_period, 7);
        chk("t2_sda", last_sda, 1);
        chk("t2_smp", last_smp, 1);
        chk("t2_excl", multi, 0);

        // slave stretch of 40 clocks
        lo_cnt = 16'd20; hi_cnt = 16'd30;
        wait_downs("t3_to", 2, 200);
        stretch_en = 1'b1; hold = 1'b1;
        wait_rise("t3_rise", 100);
        u0 = up_cnt;
        chk("t3_w0", 32'(stretching), 0);
        step();
        chk("t3_w1", 32'(stretching), 0);
        step();
        chk("t3_w2", {stretching, s_clk, busy}, 3'b111);
        repeat (36) step();
        chk("t3_hold", 32'(stretching), 1);
        chk("t3_no_up", up_cnt, u0);
        hold = 1'b0;
        step();
        chk("t3_rel1", {stretching, strob_up}, 2'b10);
        step();
        chk("t3_rel2", {stretching, strob_up}, 2'b00);
        step();
        chk("t3_up", 32'(strob_up), 1);
        wait_downs("t3_to2", 1, 100);
        chk("t3_hphase", last_hphase, 31);
        stretch_en = 1'b0;

        // en dropped at LOW cnt 10
        repeat (10) step();
        en = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("t4_idle_lat", k, 43);
        chk("t4_low", last_low, 21);
        chk("t4_idle_outs", {s_clk, scl_oe, busy, stretching}, 4'b1000);
        dc = down_cnt;
        repeat (50) step();
        chk("t4_no_down", down_cnt, dc);
        en = 1'b1;
        step();
        chk("t4_restart", {strob_down, s_clk, busy}, 3'b101);

        // hi code changed mid-HIGH
        hi_cnt = 16'd248;
        wait_downs("t5_to", 2, 1000);
        k = 0;
        while (strob_up !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk("t5_in_high", 32'(strob_up), 1);
        repeat (5) step();
        hi_cnt = 16'd100;
        wait_downs("t5_to2", 1, 600);
        chk("t5_cur_high", last_hphase, 249);
        wait_downs("t5_to3", 1, 600);
        chk("t5_next_high", last_hphase, 101);

        // reset during a stretch
        hi_cnt = 16'd30; stretch_en = 1'b1;
        wait_downs("t6_to", 1, 300);
        hold = 1'b1;
        wait_rise("t6_rise", 100);
        repeat (5) step();
        chk("t6_stretch", 32'(stretching), 1);
        rst = 1'b0;
        #1;
        chk("t6_async", {s_clk, scl_oe, strob_down, strob_up, strob_sda, strob_smp, stretching, busy}, 8'b1000_0000);
        hold = 1'b0;
        step(); step();
        chk("t6_held", {s_clk, scl_oe, strob_down, strob_up, strob_sda, strob_smp, stretching, busy}, 8'b1000_0000);
        rst = 1'b1;
        step();
        chk("t6_first_down", {strob_down, s_clk, busy}, 3'b101);

        chk("excl_all", multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Parametrised I2C SCL timing generator, the successor to the fixed 100 kHz clock divider. It adds runtime-programmable low and high times, enable/idle control, and slave clock-stretching detection through a synchronised SCL readback. It also produces quarter-phase strobes for SDA launch and sample. It sits between the I2C byte/bit engine, which consumes the strobes, and the open-drain SCL pad.

Parameters:
CNT_W, 16, width of phase counters and of lo_cnt/hi_cnt
SYNC_STAGES, 2, flip-flop stages on scl_in (minimum 2)
MIN_CNT, 2, floor applied to latched lo_cnt/hi_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  run request; level-sensitive
lo_cnt  in  CNT_W  low-phase length code
hi_cnt  in  CNT_W  high-phase length code
stretch_en  in  1  1 = honour slave clock stretching
scl_in  in  1  raw SCL pad readback (asynchronous)
s_clk  out  1  intended SCL level
scl_oe  out  1  open-drain pull-low enable, equal to ~s_clk
strob_down  out  1  1-cycle pulse on s_clk falling edge
strob_up  out  1  1-cycle pulse when bus high is confirmed
strob_sda  out  1  1-cycle pulse at mid-low (SDA change point)
strob_smp  out  1  1-cycle pulse at mid-high (SDA sample point)
stretching  out  1  slave is holding SCL low
busy  out  1  state != IDLE

Behaviour:
- One clock. Reset is asynchronous and active-low (rst); the port is named rst.
- Reset values: state IDLE; s_clk=1; scl_oe=0; all strobes 0; stretching=0; busy=0; cnt=0; shadow regs lo_q/hi_q=MIN_CNT; synchroniser all 1.
- Asserting rst at any point, including mid-stretch, returns everything to reset values immediately.
- Shadow latch: lo_q/hi_q load from lo_cnt/hi_cnt only on IDLE->LOW and HIGH->LOW transitions. A value below MIN_CNT is clamped to MIN_CNT. Changes to the inputs mid-period have no effect until the next period.
- IDLE: s_clk=1. If en=1: latch, s_clk<=0, strob_down=1 for that cycle, cnt<=0, go to LOW.
- LOW: cnt increments each cycle.
  - strob_sda=1 when cnt==lo_q>>1.
  - At cnt==lo_q: s_clk<=1, cnt<=0, go to WAIT_HIGH.
  - Low time is exactly lo_q+1 clocks.
- WAIT_HIGH: scl_sync is the output of the SYNC_STAGES synchroniser on scl_in.
  - If stretch_en=0, or scl_sync==1: strob_up=1, cnt<=0, go to HIGH.
  - Otherwise stay, and increment wait counter wcnt (cleared on entry).
  - stretching=1 while in WAIT_HIGH with scl_sync==0 and wcnt>=SYNC_STAGES; 0 elsewhere.
  - wcnt saturates and never wraps.
- HIGH: cnt increments each cycle.
  - strob_smp=1 when cnt==hi_q>>1.
  - At cnt==hi_q with en=1: s_clk<=0, strob_down=1, latch, cnt<=0, go to LOW.
  - At cnt==hi_q with en=0: go to IDLE, s_clk stays 1, no strob_down.
- Timing with no stretching: high time is hi_q+2 clocks (WAIT_HIGH plus HIGH); period is lo_q+hi_q+3 clocks. With a 50 MHz clock, lo=249 and hi=248 give a 500-clock period (100 kHz, 50 % duty).
- en is sampled only at the end of HIGH and in IDLE. Deasserting en mid-period always completes the current period cleanly.
- Strobes are mutually exclusive in any cycle. The clamp at MIN_CNT guarantees the mid strobes never coincide with edge strobes.
- Counter compare is equality only. cnt never exceeds lo_q/hi_q, so there is no wrap.

Decomposition:
- Shared package i2c_pkg:
  - state encoding (IDLE, LOW, WAIT_HIGH, HIGH)
  - CPU_CLK and DIV_CLK constants
  - derived default lo/hi codes ((CPU_CLK/DIV_CLK)/2-1 and (CPU_CLK/DIV_CLK)/2-2)
- Sub-module i2c_sync: a SYNC_STAGES-deep flip-flop synchroniser with reset value 1, reusable for the SDA readback.

Test Plan:
1. Release rst; en=1, lo=249, hi=248, stretch_en=0 -> s_clk low 250 and high 250 clocks; period 500; strob_down at the fall; strob_sda at LOW cnt 124; strob_up 1 clock after the rise; strob_smp at HIGH cnt 124.
2. lo=0, hi=1 -> both clamped to 2; low 3 clocks, high 4 clocks; strob_sda at LOW cnt 1; strob_smp at HIGH cnt 1; no two strobes in the same cycle.
3. stretch_en=1, scl_in held 0 for 40 clocks after s_clk rises -> stays in WAIT_HIGH; stretching=1 from wcnt=2 until scl_sync rises; strob_up only after scl_sync=1; the subsequent HIGH lasts hi_q+1 clocks.
4. en dropped at LOW cnt 10 -> period completes; IDLE after the HIGH end; s_clk=1; busy=0; no further strob_down; re-raising en restarts with strob_down.
5. hi_cnt changed 248->100 during HIGH -> the current HIGH still ends at cnt 248; the next period's HIGH ends at cnt 100.
6. rst pulsed low during a stretch (stretching=1) -> outputs take reset values asynchronously; after release with en=1, the first strob_down occurs on the first post-release clock.
